// File: rtl/vga_pkg.sv
// Timing constants and lock-state encoding shared by the VGA sink and its bench.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;
    localparam bit SYNC_POL  = 1'b0;
    localparam int H_START   = H_SYNC + H_BP;
    localparam int V_START   = V_SYNC + V_BP;

    // Column counter ceiling; reaching it means hsync has gone missing.
    localparam logic [10:0] HC_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } sink_state_e;
endpackage

// File: rtl/vga_sink_if.sv
// Link between a VGA source (timing controller + pixel source) and the sink.
interface vga_sink_if;
    import vga_pkg::*;

    // pix_en qualifies every other field on the link: hsync/vsync/rgb are only
    // meaningful on clocks where pix_en=1, and the sink has no back-pressure.
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic [11:0] pixel;
    logic        locked;
    logic        frame_start;
    logic        sync_err;
    logic [7:0]  err_cnt;
    sink_state_e dbg_state;

    modport master (
        output pix_en, hsync, vsync, rgb,
        input  h_cnt, v_cnt, valid, pixel, locked, frame_start, sync_err, err_cnt, dbg_state
    );

    modport slave (
        input  pix_en, hsync, vsync, rgb,
        output h_cnt, v_cnt, valid, pixel, locked, frame_start, sync_err, err_cnt, dbg_state
    );
endinterface

// File: rtl/sync_edge_det.sv
// Strobe-qualified assert-edge detector for one sync line of configurable polarity.
module sync_edge_det #(
    parameter bit SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en_i,
    input  logic sync_i,
    output logic assert_edge_o
);
    logic active;
    logic prev_q;

    assign active        = (sync_i == SYNC_POL);
    assign assert_edge_o = pix_en_i & active & ~prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else if (pix_en_i) begin
            prev_q <= active;
        end
    end
endmodule

// File: rtl/vga_sink.sv
// VGA receiver: recovers pixel coordinates from hsync/vsync, locks to frame timing
// and reports timing violations.
module vga_sink #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int H_TOTAL   = vga_pkg::H_TOTAL,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter int V_TOTAL   = vga_pkg::V_TOTAL,
    parameter bit SYNC_POL  = vga_pkg::SYNC_POL
) (
    input logic       clk,
    input logic       rst,
    vga_sink_if.slave bus
);
    import vga_pkg::*;

    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic        h_edge, v_edge;
    logic [10:0] hc_q, hc_d, h_off;
    logic [9:0]  vc_q, vc_d, v_off;
    logic        exempt_q, exempt_d;
    logic        line_err, miss_h, frame_err, fail, report;
    logic        in_win, valid_d;
    sink_state_e state_q, state_d;

    logic [9:0]  h_cnt_q, v_cnt_q;
    logic [11:0] pixel_q;
    logic        valid_q, frame_start_q, sync_err_q;
    logic [7:0]  err_cnt_q;

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_edge (
        .clk(clk), .rst(rst), .pix_en_i(bus.pix_en), .sync_i(bus.hsync), .assert_edge_o(h_edge)
    );

    sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_edge (
        .clk(clk), .rst(rst), .pix_en_i(bus.pix_en), .sync_i(bus.vsync), .assert_edge_o(v_edge)
    );

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (bus.pix_en) begin
            if (h_edge)              hc_d = '0;
            else if (hc_q != HC_MAX) hc_d = hc_q + 11'd1;
            if (v_edge)      vc_d = '0;
            else if (h_edge) vc_d = vc_q + 10'd1;
        end

        line_err  = h_edge && !exempt_q && (hc_q != 11'(H_TOTAL - 1));
        miss_h    = bus.pix_en && !h_edge && (hc_q == HC_MAX - 11'd1);
        frame_err = v_edge && (vc_q != 10'(V_TOTAL));
        fail      = line_err || miss_h || frame_err;
        report    = fail && (state_q != UNLOCKED);

        // The first line after acquisition starts mid-count, so its length is not judged.
        exempt_d = exempt_q;
        if (bus.pix_en) begin
            if (state_q == UNLOCKED) exempt_d = 1'b1;
            else if (h_edge)         exempt_d = 1'b0;
        end

        in_win = (hc_d >= 11'(H_START)) && (hc_d < 11'(H_START + H_VISIBLE)) &&
                 (vc_d >= 10'(V_START)) && (vc_d < 10'(V_START + V_VISIBLE));
        valid_d = in_win && (state_d == LOCKED);
        h_off   = hc_d - 11'(H_START);
        v_off   = vc_d - 10'(V_START);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (v_edge) state_d = ACQUIRE;
            ACQUIRE: begin
                if (fail)        state_d = UNLOCKED;
                else if (v_edge) state_d = LOCKED;
            end
            LOCKED:   if (fail) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= UNLOCKED;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            exempt_q      <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            pixel_q       <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (bus.pix_en) begin
                hc_q          <= hc_d;
                vc_q          <= vc_d;
                exempt_q      <= exempt_d;
                pixel_q       <= bus.rgb;
                valid_q       <= valid_d;
                frame_start_q <= valid_d && (hc_d == 11'(H_START)) && (vc_d == 10'(V_START));
                sync_err_q    <= report;
                if (in_win) begin
                    h_cnt_q <= h_off[9:0];
                    v_cnt_q <= v_off;
                end
                if (report && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign bus.h_cnt       = h_cnt_q;
    assign bus.v_cnt       = v_cnt_q;
    assign bus.valid       = valid_q;
    assign bus.pixel       = pixel_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.frame_start = frame_start_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_vga_sink.sv
// Bench for vga_sink using a shrunken raster so whole frames fit in a short run.
module tb_vga_sink;
    localparam int TH_VIS   = 8;
    localparam int TH_SYNC  = 2;
    localparam int TH_BP    = 3;
    localparam int TH_TOT   = 16;
    localparam int TV_VIS   = 4;
    localparam int TV_SYNC  = 1;
    localparam int TV_BP    = 2;
    localparam int TV_TOT   = 10;
    localparam int TH_START = TH_SYNC + TH_BP;
    localparam int TV_START = TV_SYNC + TV_BP;
    localparam int VOFF     = 1;
    localparam int NVEC     = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;

    vga_sink_if bus();

    vga_sink #(
        .H_VISIBLE(TH_VIS), .H_SYNC(TH_SYNC), .H_BP(TH_BP), .H_TOTAL(TH_TOT),
        .V_VISIBLE(TV_VIS), .V_SYNC(TV_SYNC), .V_BP(TV_BP), .V_TOTAL(TV_TOT),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_valid, cnt_fs, cnt_se;

    // Reference model: sync levels, line/row position, lock progress.
    bit          m_hprev, m_vprev, m_exempt;
    int          m_hc, m_vc, m_phase, m_err, m_h, m_v;
    bit          m_valid, m_fs, m_se;
    logic [11:0] m_pix;

    typedef struct {
        int pre_gap;
        int nlines;
        int long_line;
        int exp_valid;
        int exp_fs;
        int exp_se;
        int exp_locked;
        int exp_err;
        int exp_gap_err_at;
    } frame_vec_t;

    frame_vec_t vecs[NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_hprev = 0; m_vprev = 0; m_exempt = 0;
        m_hc = 0; m_vc = 0; m_phase = 0; m_err = 0; m_h = 0; m_v = 0;
        m_valid = 0; m_fs = 0; m_se = 0; m_pix = '0;
    endfunction

    function automatic void model_step(input logic hs, input logic vs, input logic [11:0] c);
        bit ha, va, he, ve, bad, win;
        int nhc, nvc;
        ha = (hs == 1'b0);
        va = (vs == 1'b0);
        he = ha && !m_hprev;
        ve = va && !m_vprev;
        m_hprev = ha;
        m_vprev = va;
        bad = 0;
        if (he && !m_exempt && m_hc != TH_TOT - 1) bad = 1;
        if (ve && m_vc != TV_TOT) bad = 1;
        if (!he && m_hc == 2046) bad = 1;
        nhc = he ? 0 : ((m_hc < 2047) ? m_hc + 1 : 2047);
        nvc = ve ? 0 : (he ? (m_vc + 1) % 1024 : m_vc);
        if (m_phase == 0) m_exempt = 1;
        else if (he)      m_exempt = 0;
        m_se = bad && (m_phase != 0);
        if (m_se && m_err < 255) m_err++;
        if (m_se)                    m_phase = 0;
        else if (ve && m_phase < 2)  m_phase++;
        m_hc = nhc;
        m_vc = nvc;
        win = (nhc >= TH_START) && (nhc < TH_START + TH_VIS) &&
              (nvc >= TV_START) && (nvc < TV_START + TV_VIS);
        m_valid = win && (m_phase == 2);
        if (win) begin
            m_h = (nhc - TH_START) & 1023;
            m_v = (nvc - TV_START) & 1023;
        end
        m_pix = c;
        m_fs  = m_valid && (m_h == 0) && (m_v == 0);
    endfunction

    task automatic check_all();
        chk("valid",       int'(bus.valid),       int'(m_valid));
        chk("h_cnt",       int'(bus.h_cnt),       m_h);
        chk("v_cnt",       int'(bus.v_cnt),       m_v);
        chk("pixel",       int'(bus.pixel),       int'(m_pix));
        chk("locked",      int'(bus.locked),      int'(m_phase == 2));
        chk("frame_start", int'(bus.frame_start), int'(m_fs));
        chk("sync_err",    int'(bus.sync_err),    int'(m_se));
        chk("err_cnt",     int'(bus.err_cnt),     m_err);
    endtask

    task automatic strobe(input logic hs, input logic vs, input logic [11:0] c);
        int gap;
        bus.pix_en = 1'b1;
        bus.hsync  = hs;
        bus.vsync  = vs;
        bus.rgb    = c;
        @(posedge clk);
        #1;
        bus.pix_en = 1'b0;
        model_step(hs, vs, c);
        check_all();
        cnt_valid += int'(bus.valid);
        cnt_fs    += int'(bus.frame_start);
        cnt_se    += int'(bus.sync_err);
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin
            @(posedge clk);
            #1;
            m_fs = 0;
            m_se = 0;
            check_all();
        end
    endtask

    // Sync-first raster: hsync at columns 0..1; vsync asserts one pixel into line 0.
    task automatic drive_lines(input int first, input int last, input int long_line);
        logic hs, vs;
        logic [11:0] c;
        int len;
        for (int ln = first; ln < last; ln++) begin
            len = (ln == long_line) ? TH_TOT + 1 : TH_TOT;
            for (int x = 0; x < len; x++) begin
                hs = (x < TH_SYNC) ? 1'b0 : 1'b1;
                vs = ((ln == 0 && x >= VOFF) || (ln > 0 && ln < TV_SYNC) ||
                      (ln == TV_SYNC && x < VOFF)) ? 1'b0 : 1'b1;
                if (ln >= TV_START && ln < TV_START + TV_VIS && x >= TH_START && x < TH_START + TH_VIS)
                    c = {4'(ln - TV_START), 4'(x - TH_START), 4'h5};
                else
                    c = 12'($urandom);
                strobe(hs, vs, c);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap_err_at, se_before, nl, ll, r;

        //            gap   lines long  valid fs se lock err gap_at
        vecs[0]  = '{0,    10,  -1,   0,   0, 0, 0,   0, -1};
        vecs[1]  = '{0,    10,  -1,   32,  1, 0, 1,   0, -1};
        vecs[2]  = '{0,    10,  -1,   32,  1, 0, 1,   0, -1};
        vecs[3]  = '{0,    10,   4,   16,  1, 1, 0,   1, -1};
        vecs[4]  = '{0,    10,  -1,   0,   0, 0, 0,   1, -1};
        vecs[5]  = '{0,    10,  -1,   32,  1, 0, 1,   1, -1};
        vecs[6]  = '{0,    9,   -1,   32,  1, 0, 1,   1, -1};
        vecs[7]  = '{0,    10,  -1,   0,   0, 1, 0,   2, -1};
        vecs[8]  = '{0,    10,  -1,   0,   0, 0, 0,   2, -1};
        vecs[9]  = '{0,    10,  -1,   32,  1, 0, 1,   2, -1};
        vecs[10] = '{2100, 10,  -1,   0,   0, 1, 0,   3, 2032};
        vecs[11] = '{0,    10,  -1,   32,  1, 0, 1,   3, -1};

        bus.pix_en = 1'b0;
        bus.hsync  = 1'b1;
        bus.vsync  = 1'b1;
        bus.rgb    = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        for (int i = 0; i < NVEC; i++) begin
            cnt_valid = 0;
            cnt_fs    = 0;
            cnt_se    = 0;
            if (vecs[i].pre_gap > 0) begin
                gap_err_at = -1;
                for (int k = 1; k <= vecs[i].pre_gap; k++) begin
                    se_before = cnt_se;
                    strobe(1'b1, 1'b1, 12'($urandom));
                    if (cnt_se != se_before && gap_err_at < 0) gap_err_at = k;
                end
                chk("gap_err_at", gap_err_at, vecs[i].exp_gap_err_at);
            end
            drive_lines(0, vecs[i].nlines, vecs[i].long_line);
            chk("frame_valid_cnt", cnt_valid, vecs[i].exp_valid);
            chk("frame_fs_cnt",    cnt_fs,    vecs[i].exp_fs);
            chk("frame_se_cnt",    cnt_se,    vecs[i].exp_se);
            chk("frame_locked",    int'(bus.locked),  vecs[i].exp_locked);
            chk("frame_err_cnt",   int'(bus.err_cnt), vecs[i].exp_err);
        end

        for (int f = 0; f < 6; f++) begin
            r  = int'($urandom_range(0, 5));
            nl = (r == 0) ? 9 : ((r == 1) ? 11 : 10);
            ll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            drive_lines(0, nl, ll);
        end

        // Mid-frame asynchronous reset while the strobe is idle.
        drive_lines(0, 5, -1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check_all();
        drive_lines(5, 10, -1);
        drive_lines(0, 10, -1);
        drive_lines(0, 10, -1);
        chk("relock_after_reset", int'(bus.locked), 1);
        chk("err_cnt_after_reset", int'(bus.err_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
